// File: rtl/reg_cmd_mst.sv
// reg_cmd_mst: valid/ready command stream to single reg bus transactions.
// Optional response timeout when REG_CMD_MST_TIMEOUT_EN is defined.
package reg_cmd_mst_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module reg_cmd_mst
  import reg_cmd_mst_pkg::*;
#(
  parameter int unsigned   AW             = 32,
  parameter int unsigned   DW             = 32,
  parameter int unsigned   TIMEOUT_CYCLES = 1024,
  parameter logic [DW-1:0] TO_VAL         = DW'(32'hDEADBEEF),
  parameter type           req_t          = reg_req_t,
  parameter type           rsp_t          = reg_rsp_t
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic            cmd_write_i,
  input  logic [DW-1:0]   cmd_wdata_i,
  input  logic [DW/8-1:0] cmd_wstrb_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic            rsp_error_o,
  output logic            rsp_timeout_o,
  output req_t            reg_req_o,
  input  rsp_t            reg_rsp_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wstrb_q, wstrb_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

`ifdef REG_CMD_MST_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  logic          expire;

  assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;

  assign unused_cfg = ^{TO_VAL, TIMEOUT_CYCLES};
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef REG_CMD_MST_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          write_d = cmd_write_i;
          wdata_d = cmd_wdata_i;
          wstrb_d = cmd_wstrb_i;
`ifdef REG_CMD_MST_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        if (reg_rsp_i.ready) begin
          rdata_d = reg_rsp_i.rdata;
          err_d   = reg_rsp_i.error;
`ifdef REG_CMD_MST_TIMEOUT_EN
          to_d    = 1'b0;
`endif
          state_d = RSP;
        end
`ifdef REG_CMD_MST_TIMEOUT_EN
        // abort drops req.valid mid-transfer to isolate a hung target
        else if (expire) begin
          rdata_d = TO_VAL;
          err_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RSP;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      RSP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef REG_CMD_MST_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef REG_CMD_MST_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // ready is masked by reset so no command is taken while held in reset
  assign cmd_ready_o = rst_ni && (state_q == IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = err_q;

`ifdef REG_CMD_MST_TIMEOUT_EN
  assign rsp_timeout_o = to_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  always_comb begin
    reg_req_o       = '0;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = write_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = wstrb_q;
    reg_req_o.valid = (state_q == REQ);
  end

endmodule

// File: tb/tb_reg_cmd_mst.sv
// tb_reg_cmd_mst: directed tests of reg_cmd_mst against a transaction model.
// Timeout tests are enabled when REG_CMD_MST_TIMEOUT_EN is defined.
module tb_reg_cmd_mst;
  import reg_cmd_mst_pkg::*;

  localparam int          TC  = 4;
  localparam logic [31:0] TOV = 32'hDEADBEEF;
`ifdef REG_CMD_MST_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  reg_req_t    req;
  reg_rsp_t    rsp;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_cmd_mst #(
    .AW(32),
    .DW(32),
    .TIMEOUT_CYCLES(TC),
    .TO_VAL(TOV)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr),
    .cmd_write_i(cmd_write),
    .cmd_wdata_i(cmd_wdata),
    .cmd_wstrb_i(cmd_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error),
    .rsp_timeout_o(rsp_timeout),
    .reg_req_o(req),
    .reg_rsp_i(rsp)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // target: ready after t_wait cycles of req.valid; junk data otherwise
  int          t_wait = 0;
  logic [31:0] t_rdata = '0;
  logic        t_err = 1'b0;
  int          t_cnt = 0;

  initial begin
    rsp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (req.valid) t_cnt++;
      else t_cnt = 0;
      rsp.ready = req.valid && (t_cnt == t_wait + 1);
      rsp.rdata = rsp.ready ? t_rdata : ~t_rdata;
      rsp.error = rsp.ready ? t_err : ~t_err;
    end
  end

  // transaction model: one outstanding command, done once answered
  logic        m_out, m_done, m_wr, m_err, m_to;
  int          m_cnt;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out   <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
      m_addr  <= '0;
      m_wr    <= 1'b0;
      m_wdata <= '0;
      m_wstrb <= '0;
      m_rdata <= '0;
      m_err   <= 1'b0;
      m_to    <= 1'b0;
    end else if (!m_out) begin
      if (cmd_valid) begin
        m_out   <= 1'b1;
        m_done  <= 1'b0;
        m_cnt   <= 0;
        m_addr  <= cmd_addr;
        m_wr    <= cmd_write;
        m_wdata <= cmd_wdata;
        m_wstrb <= cmd_wstrb;
      end
    end else if (!m_done) begin
      if (rsp.ready) begin
        m_done  <= 1'b1;
        m_rdata <= rsp.rdata;
        m_err   <= rsp.error;
        m_to    <= 1'b0;
      end else if (TO_EN && m_cnt == TC - 1) begin
        m_done  <= 1'b1;
        m_rdata <= TOV;
        m_err   <= 1'b1;
        m_to    <= 1'b1;
      end else begin
        m_cnt   <= m_cnt + 1;
      end
    end else if (rsp_ready) begin
      m_out <= 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, rst_n && !m_out);
    chk("req_valid", req.valid, m_out && !m_done);
    chk("req_addr", req.addr, m_addr);
    chk("req_write", req.write, m_wr);
    chk("req_wdata", req.wdata, m_wdata);
    chk("req_wstrb", req.wstrb, m_wstrb);
    chk("rsp_valid", rsp_valid, m_out && m_done);
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("rsp_error", rsp_error, m_err);
    chk("rsp_timeout", rsp_timeout, m_to);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       input int wt, input logic [31:0] rd,
                       input logic er);
    int n;
    t_wait    = wt;
    t_rdata   = rd;
    t_err     = er;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("accept_bound", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      step();
      lat++;
    end
    chk("rsp_bound", rsp_valid, 1);
  endtask

  int          lat;
  logic [31:0] tb_a [4] = '{32'h200, 32'h204, 32'h208, 32'h20C};
  logic        tb_w [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int          tb_t [4] = '{2, 0, 1, 3};
  logic [31:0] tb_r [4] = '{32'h0BADF00D, 32'h13579BDF, 32'h2468ACE0, 32'h55AA55AA};
  logic        tb_e [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    #1 rst_n = 1'b0;
    step();
    step();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_req_valid", req.valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_req_addr", req.addr, 0);
    rst_n = 1'b1;
    step();
    chk("idle_cmd_ready", cmd_ready, 1);

    issue(32'h40, 1'b0, 32'h0, 4'h0, 0, 32'h12345678, 1'b0);
    chk("t1_req_valid", req.valid, 1);
    chk("t1_req_addr", req.addr, 32'h40);
    wait_rsp(lat);
    chk("t1_lat", lat, 1);
    chk("t1_rdata", rsp_rdata, 32'h12345678);
    chk("t1_err", rsp_error, 0);
    step();

    issue(32'h0C, 1'b1, 32'hA5A5A5A5, 4'hF, TO_EN ? 3 : 5, 32'h0, 1'b0);
    for (int i = 0; i <= (TO_EN ? 3 : 5); i++) begin
      chk("t2_req_valid", req.valid, 1);
      chk("t2_req_addr", req.addr, 32'h0C);
      chk("t2_req_wdata", req.wdata, 32'hA5A5A5A5);
      chk("t2_req_wstrb", req.wstrb, 4'hF);
      chk("t2_req_write", req.write, 1);
      step();
    end
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_err", rsp_error, 0);
    chk("t2_req_drop", req.valid, 0);
    step();

    issue(32'h100, 1'b0, 32'h0, 4'h0, 0, 32'hBADCAB1E, 1'b1);
    wait_rsp(lat);
    chk("t3_lat", lat, 1);
    chk("t3_err", rsp_error, 1);
    chk("t3_rdata", rsp_rdata, 32'hBADCAB1E);
    chk("t3_timeout", rsp_timeout, 0);
    step();

    rsp_ready = 1'b0;
    issue(32'h20, 1'b0, 32'h0, 4'h0, 0, 32'h11112222, 1'b0);
    wait_rsp(lat);
    t_wait    = 0;
    t_rdata   = 32'h33334444;
    t_err     = 1'b0;
    cmd_addr  = 32'h24;
    cmd_write = 1'b0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_hold", rsp_valid, 1);
      chk("t4_cmd_ready", cmd_ready, 0);
      chk("t4_req_valid", req.valid, 0);
      chk("t4_rdata", rsp_rdata, 32'h11112222);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_idle_ready", cmd_ready, 1);
    chk("t4_idle_rsp", rsp_valid, 0);
    step();
    cmd_valid = 1'b0;
    chk("t4_next_req", req.valid, 1);
    chk("t4_next_addr", req.addr, 32'h24);
    wait_rsp(lat);
    chk("t4_next_rdata", rsp_rdata, 32'h33334444);
    step();

`ifdef REG_CMD_MST_TIMEOUT_EN
    issue(32'h30, 1'b0, 32'h0, 4'h0, 1000, 32'hCAFEF00D, 1'b0);
    for (int i = 0; i < TC; i++) begin
      chk("t5_req_valid", req.valid, 1);
      step();
    end
    chk("t5_rsp_valid", rsp_valid, 1);
    chk("t5_req_drop", req.valid, 0);
    chk("t5_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("t5_err", rsp_error, 1);
    chk("t5_timeout", rsp_timeout, 1);
    step();
    issue(32'h34, 1'b0, 32'h0, 4'h0, TC - 1, 32'h0F0F0F0F, 1'b0);
    wait_rsp(lat);
    chk("t5_late_lat", lat, 4);
    chk("t5_late_rdata", rsp_rdata, 32'h0F0F0F0F);
    chk("t5_late_timeout", rsp_timeout, 0);
    step();
`else
    issue(32'h30, 1'b0, 32'h0, 4'h0, 20, 32'hCAFEF00D, 1'b0);
    wait_rsp(lat);
    chk("t5_lat", lat, 21);
    chk("t5_rdata", rsp_rdata, 32'hCAFEF00D);
    chk("t5_timeout", rsp_timeout, 0);
    step();
`endif

    issue(32'h50, 1'b1, 32'h01020304, 4'h3, 1000, 32'h0, 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", req.valid, 0);
    chk("t6_cmd_ready", cmd_ready, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    chk("t6_req_addr", req.addr, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_no_rsp", rsp_valid, 0);
      step();
    end
    issue(32'h54, 1'b0, 32'h0, 4'h0, 0, 32'h600DF00D, 1'b0);
    wait_rsp(lat);
    chk("t6_lat", lat, 1);
    chk("t6_rdata", rsp_rdata, 32'h600DF00D);
    step();

    for (int k = 0; k < 4; k++) begin
      issue(tb_a[k], tb_w[k], ~tb_a[k], 4'hA, tb_t[k], tb_r[k], tb_e[k]);
      wait_rsp(lat);
      chk("tbl_lat", lat, tb_t[k] + 1);
      chk("tbl_rdata", rsp_rdata, tb_r[k]);
      chk("tbl_err", rsp_error, tb_e[k]);
      step();
    end

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got stuck want finish");
    $fatal(1);
  end

endmodule
